apb_timer: RTL

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_timer.sv
// APB down-counting timer with a 16-bit prescaler, one-shot/periodic modes
// and a level interrupt. Every access takes exactly one wait state: the
// request is captured on entry to ACK, and writes commit on leaving ACK.
module apb_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32   // only 32 is supported
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  IRQ
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_LOAD     = 8'h08;
  localparam logic [7:0] OFF_COUNT    = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  // Only the low address byte is decoded.
  if (ADDR_WIDTH > 8) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^PADDR[ADDR_WIDTH-1:8];
  end

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;
  logic                    en_q, en_d;
  logic                    per_q, per_d;
  logic                    ie_q, ie_d;
  logic [15:0]             prescale_q, prescale_d;
  logic [31:0]             load_q, load_d;
  logic [31:0]             count_q, count_d;
  logic                    exp_q, exp_d;
  logic [15:0]             psc_q, psc_d;

  logic [7:0]              offset;
  logic                    access_err;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    start;
  logic                    commit;
  logic                    wr_ctrl, wr_prescale, wr_load, wr_status;
  logic [31:0]             ctrl_wdata, prescale_wdata, load_wdata;
  logic                    run, tick, expire;

  // Byte-lane merge of write data into the current register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  // Address decode, error classification and read-data mux.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    offset     = PADDR[7:0];
    access_err = (offset[1:0] != 2'b00) || (offset > OFF_STATUS) ||
                 (PWRITE && (offset == OFF_COUNT));
    rdata      = '0;
    unique case (offset)
      OFF_CTRL:     rdata = {29'b0, ie_q, per_q, en_q};
      OFF_PRESCALE: rdata = {16'b0, prescale_q};
      OFF_LOAD:     rdata = load_q;
      OFF_COUNT:    rdata = count_q;
      OFF_STATUS:   rdata = {31'b0, exp_q};
      default:      rdata = '0;
    endcase
  end

  // Handshake FSM: state register.
  always_ff @(posedge PCLK) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Handshake FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (PSEL && PENABLE) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake FSM: outputs and response capture on the IDLE->ACK edge.
  always_comb begin
    PREADY    = (state_q == S_ACK);
    start     = (state_q == S_IDLE) && PSEL && PENABLE;
    prdata_d  = (start && !access_err && !PWRITE) ? rdata : '0;
    pslverr_d = start && access_err;
    commit    = (state_q == S_ACK) && PSEL && PWRITE && !pslverr_q;
  end

  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign IRQ     = exp_q && ie_q;

  // Register writes, prescaler and counter next-state.
  always_comb begin
    wr_ctrl        = commit && (offset == OFF_CTRL);
    wr_prescale    = commit && (offset == OFF_PRESCALE);
    wr_load        = commit && (offset == OFF_LOAD);
    wr_status      = commit && (offset == OFF_STATUS);
    ctrl_wdata     = merge_bytes({29'b0, ie_q, per_q, en_q}, PWDATA[31:0], PSTRB);
    prescale_wdata = merge_bytes({16'b0, prescale_q}, PWDATA[31:0], PSTRB);
    load_wdata     = merge_bytes(load_q, PWDATA[31:0], PSTRB);

    // A CTRL write clearing EN freezes the timer on its commit edge.
    run    = en_q && !(wr_ctrl && !ctrl_wdata[0]);
    tick   = run && (psc_q == prescale_q);
    expire = tick && (count_q == 32'd0);

    en_d       = en_q;
    per_d      = per_q;
    ie_d       = ie_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;
    psc_d      = psc_q;
    exp_d      = exp_q;

    if (run) begin
      if (tick) begin
        psc_d = 16'd0;
        if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else if (per_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        psc_d = psc_q + 16'd1;
      end
    end

    if (wr_ctrl) begin
      en_d  = ctrl_wdata[0];
      per_d = ctrl_wdata[1];
      ie_d  = ctrl_wdata[2];
      if (ctrl_wdata[0] && !en_q) psc_d = 16'd0;
    end
    if (wr_prescale) prescale_d = prescale_wdata[15:0];
    // A LOAD write overrides whatever the timer did this cycle.
    if (wr_load) begin
      load_d  = load_wdata;
      count_d = load_wdata;
      psc_d   = 16'd0;
    end

    // Expiry is applied after the clear so a coincident set wins.
    if (wr_status && PSTRB[0] && PWDATA[0]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;
  end

  // Register state, response flops and timer with synchronous reset.
  always_ff @(posedge PCLK) begin
    // NOTE: every flop here is a plain control/status register, so all of
    // them are reset; there is no storage array that could skip reset.
    if (!PRESETn) begin
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      en_q       <= 1'b0;
      per_q      <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= 16'd0;
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      exp_q      <= 1'b0;
      psc_q      <= 16'd0;
    end else begin
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      en_q       <= en_d;
      per_q      <= per_d;
      ie_q       <= ie_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      count_q    <= count_d;
      exp_q      <= exp_d;
      psc_q      <= psc_d;
    end
  end

endmodule
